// File: rtl/fifo_pkg.sv
// Shared constants and parameter checks for the synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  function automatic bit fifo_th_ok(input int afull_th, input int aempty_th, input int depth);
    return (afull_th <= depth) && (aempty_th < depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with wrap-bit pointers, threshold flags,
// sticky error flags and selectable registered / show-ahead read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int AFULL_TH   = (2**ADDR_W) - 2,
  parameter int AEMPTY_TH  = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  input  logic              clr_err,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] AFULL_V  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_V = (ADDR_W+1)'(AEMPTY_TH);

  generate
    if (!fifo_th_ok(AFULL_TH, AEMPTY_TH, DEPTH)) begin : g_bad_th
      $fatal(1, "sync_fifo_param: AFULL_TH must be <= DEPTH and AEMPTY_TH < DEPTH");
    end
  endgenerate

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full_w, empty_w, push_w, pop_w;
  logic [DATA_W-1:0] rdata_w;

  assign full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign empty_w = (wr_ptr_q == rd_ptr_q);

  // Handshake: a push is taken when wr_en=1 and full=0, a pop when rd_en=1 and
  // empty=0; both flags come only from registered pointers, so acceptance never
  // depends combinationally on the other request.
  assign push_w = wr_en && !full_w;
  assign pop_w  = rd_en && !empty_w;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full_w)  overflow_d  = 1'b1;
    if (rd_en && empty_w) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_w),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata_w)
  );

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      // Gate with empty so stale memory never reaches dout after a reset.
      assign dout     = empty_w ? '0 : rdata_w;
      assign rd_valid = !empty_w;
    end else begin : g_registered
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              rd_valid_q, rd_valid_d;

      always_comb begin
        dout_d     = dout_q;
        rd_valid_d = pop_w;
        if (pop_w) dout_d = rdata_w;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          dout_q     <= dout_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign dout     = dout_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = full_w;
  assign empty        = empty_w;
  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AFULL_V);
  assign almost_empty = (count <= AEMPTY_V);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered-read instance plus a show-ahead instance.
module tb_sync_fifo_param;

  logic       clk, rst_n;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] din, dout;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       sa_wr_en, sa_rd_en, sa_clr_err;
  logic [7:0] sa_din, sa_dout;
  logic       sa_rd_valid, sa_full, sa_empty, sa_af, sa_ae, sa_overflow, sa_underflow;
  logic [4:0] sa_count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2), .SHOW_AHEAD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2), .SHOW_AHEAD(1)) u_sa (
    .clk(clk), .rst_n(rst_n), .wr_en(sa_wr_en), .din(sa_din), .rd_en(sa_rd_en),
    .dout(sa_dout), .rd_valid(sa_rd_valid), .full(sa_full), .empty(sa_empty),
    .almost_full(sa_af), .almost_empty(sa_ae), .count(sa_count),
    .clr_err(sa_clr_err), .overflow(sa_overflow), .underflow(sa_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_flags(input string tag, input int cnt);
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".afull"}, 32'(almost_full), 32'(cnt >= 14));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(cnt <= 2));
    chk({tag, ".full"}, 32'(full), 32'(cnt == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 0; rd_en = 0; clr_err = 0; din = '0;
    sa_wr_en = 0; sa_rd_en = 0; sa_clr_err = 0; sa_din = '0;
    tick(); tick();
    chk_flags("reset", 0);
    chk("reset.dout", 32'(dout), 0);
    chk("reset.rd_valid", 32'(rd_valid), 0);
    chk("reset.overflow", 32'(overflow), 0);
    chk("reset.underflow", 32'(underflow), 0);
    rst_n = 1'b1;
    tick();

    // fill with 0x00,0x04,...,0x3C
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'(i * 4);
      exp_q.push_back(8'(i * 4));
      tick();
      chk_flags($sformatf("fill%0d", i), i + 1);
    end
    din = 8'hFF;
    tick();
    chk("fill.overflow", 32'(overflow), 1);
    chk("fill.count_after_ovf", 32'(count), 16);
    wr_en = 0;

    // drain; the first pop coincides with a rejected push while full
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      wr_en = (i == 0); din = 8'hEE;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("drain%0d.dout", i), 32'(dout), 32'(e));
      chk($sformatf("drain%0d.rd_valid", i), 32'(rd_valid), 1);
      chk_flags($sformatf("drain%0d", i), 15 - i);
    end
    wr_en = 0;
    tick();
    chk("drain.underflow", 32'(underflow), 1);
    chk("drain.no_valid", 32'(rd_valid), 0);
    chk("drain.dout_hold", 32'(dout), 32'h3C);
    chk("drain.overflow_sticky", 32'(overflow), 1);

    // clear: set beats clear for underflow, overflow clears
    clr_err = 1;
    tick();
    chk("clr.overflow", 32'(overflow), 0);
    chk("clr.underflow_set_wins", 32'(underflow), 1);
    rd_en = 0;
    tick();
    chk("clr.underflow", 32'(underflow), 0);
    clr_err = 0;

    // wrap: hold count at 5 through 40 concurrent push/pop cycles
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; din = 8'(8'h80 + i);
      exp_q.push_back(din);
      tick();
    end
    chk("wrap.count_start", 32'(count), 5);
    for (int i = 0; i < 40; i++) begin
      wr_en = 1; rd_en = 1; din = 8'(8'hC0 + i);
      tick();
      e = exp_q.pop_front();
      exp_q.push_back(din);
      chk($sformatf("wrap%0d.dout", i), 32'(dout), 32'(e));
      chk($sformatf("wrap%0d.count", i), 32'(count), 5);
    end
    wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("wrap_tail%0d.dout", i), 32'(dout), 32'(e));
    end
    rd_en = 0;
    tick();
    chk_flags("wrap.end", 0);

    // show-ahead instance
    chk("sa.idle_valid", 32'(sa_rd_valid), 0);
    chk("sa.idle_dout", 32'(sa_dout), 0);
    sa_wr_en = 1; sa_din = 8'hA5;
    tick();
    sa_din = 8'h5A;
    chk("sa.fwft_dout", 32'(sa_dout), 32'hA5);
    chk("sa.fwft_valid", 32'(sa_rd_valid), 1);
    tick();
    sa_wr_en = 0;
    chk("sa.hold_dout", 32'(sa_dout), 32'hA5);
    chk("sa.count2", 32'(sa_count), 2);
    sa_rd_en = 1;
    tick();
    chk("sa.next_dout", 32'(sa_dout), 32'h5A);
    tick();
    sa_rd_en = 0;
    chk("sa.empty_valid", 32'(sa_rd_valid), 0);
    chk("sa.empty_flag", 32'(sa_empty), 1);
    sa_wr_en = 1; sa_rd_en = 1; sa_din = 8'h3C;
    #1;
    chk("sa.no_bypass", 32'(sa_rd_valid), 0);
    tick();
    sa_wr_en = 0; sa_rd_en = 0;
    chk("sa.underflow", 32'(sa_underflow), 1);
    chk("sa.push_taken", 32'(sa_count), 1);
    chk("sa.dout_3c", 32'(sa_dout), 32'h3C);

    // reset mid-operation at count 9
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; din = 8'(8'h11 * (i + 1));
      tick();
    end
    wr_en = 0; rd_en = 1;
    tick();
    rd_en = 0;
    chk("mid.count9", 32'(count), 9);
    chk("mid.dout", 32'(dout), 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.empty", 32'(empty), 1);
    chk("mid_rst.count", 32'(count), 0);
    chk("mid_rst.dout", 32'(dout), 0);
    chk("mid_rst.rd_valid", 32'(rd_valid), 0);
    chk("mid_rst.aempty", 32'(almost_empty), 1);
    chk("mid_rst.sa_empty", 32'(sa_empty), 1);
    chk("mid_rst.sa_dout", 32'(sa_dout), 0);
    chk("mid_rst.sa_underflow", 32'(sa_underflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1; din = 8'h77;
    tick();
    wr_en = 0; rd_en = 1;
    tick();
    rd_en = 0;
    chk("post_rst.dout", 32'(dout), 32'h77);
    chk("post_rst.empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits, 1 or more.
REQ-002 SHALL have parameter ADDR_W, default 4: depth DEPTH = 2**ADDR_W entries, 1 or more.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-2: almost_full asserts when count >= AFULL_TH.
REQ-004 SHALL have parameter AEMPTY_TH, default 2: almost_empty asserts when count <= AEMPTY_TH.
REQ-005 SHALL have parameter SHOW_AHEAD, default 0: 0 gives registered read, 1 gives first-word-fall-through.
REQ-006 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port: wr_en  input  1  push request.
REQ-009 SHALL have port: din  input  DATA_W  push data.
REQ-010 SHALL have port: rd_en  input  1  pop request.
REQ-011 SHALL have port: dout  output  DATA_W  read data.
REQ-012 SHALL have port: rd_valid  output  1  dout holds valid data.
REQ-013 SHALL have ports: full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port: count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port: clr_err  input  1  synchronous clear of the sticky error flags.
REQ-016 SHALL have ports: overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL accept a push iff wr_en=1 and full=0; din is written at wr_ptr and wr_ptr increments.
REQ-018 SHALL accept a pop iff rd_en=1 and empty=0; rd_ptr increments.
REQ-019 SHALL use (ADDR_W+1)-bit pointers, with the MSB as the wrap bit and ADDR_W LSBs as the memory index; pointers wrap modulo 2*DEPTH.
REQ-020 SHALL derive full = (wr_ptr MSB != rd_ptr MSB) and (indices equal), and empty = (wr_ptr == rd_ptr); both are registered-state functions, with no combinational path from wr_en or rd_en.
REQ-021 SHALL compute count = wr_ptr - rd_ptr modulo 2**(ADDR_W+1); an accepted push plus pop in the same cycle leaves count unchanged.
REQ-022 SHALL handle simultaneous wr_en and rd_en when full: pop accepted, push rejected, overflow set.
REQ-023 SHALL handle simultaneous wr_en and rd_en when empty: push accepted, pop rejected, underflow set; with SHOW_AHEAD=1 the written word does not bypass to dout in the same cycle.
REQ-024 SHALL set overflow on wr_en=1 with full=0 false (i.e. full=1); set underflow on rd_en=1 with empty=1; both hold until clr_err=1, and set takes priority over clr_err in the same cycle.
REQ-025 SHALL, with SHOW_AHEAD=0, register dout from mem[rd_ptr index] on an accepted pop, giving 1-cycle latency; rd_valid=1 for exactly the cycle after each accepted pop, and dout holds its value otherwise.
REQ-026 SHALL, with SHOW_AHEAD=1, drive dout = mem[rd_ptr index] and rd_valid = !empty; an accepted pop advances to the next word on the following cycle.
REQ-027 SHALL preserve strict FIFO order across any number of pointer wraps.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear wr_ptr, rd_ptr, overflow, underflow, rd_valid and dout to 0; empty=1, full=0, count=0, almost_empty=1, almost_full=0.
REQ-029 SHALL NOT reset the memory array; after a reset asserted mid-operation, stale contents are never visible because empty=1.
REQ-030 SHALL accept no push or pop on the first clk edge coincident with rst_n deassertion only if rst_n is still low at that edge.

Structure
REQ-031 SHALL place shared items in package fifo_pkg: the default width and depth constants, and a function that checks AFULL_TH and AEMPTY_TH against DEPTH.
REQ-032 SHALL have one sub-module, fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
REQ-033 SHALL fail elaboration if AFULL_TH > DEPTH or AEMPTY_TH >= DEPTH.

Verification (DATA_W=8, ADDR_W=4)
REQ-034 SHALL cover fill: push 16 words 0x00,0x04,...,0x3C -> full=1 and count=16 after the 16th; a 17th push sets overflow=1 and the contents are unchanged.
REQ-035 SHALL cover drain (SHOW_AHEAD=0): pop 16 -> dout=0x00..0x3C in order, each with rd_valid 1 cycle after rd_en; then empty=1; a 17th pop sets underflow=1.
REQ-036 SHALL cover wrap: 40 cycles of concurrent push/pop at count=5 -> count stays 5, order is preserved, and pointers have wrapped at least twice.
REQ-037 SHALL cover thresholds: AFULL_TH=14, AEMPTY_TH=2; step count 0->16->0 -> almost_full high exactly for counts 14..16 and almost_empty high exactly for counts 0..2.
REQ-038 SHALL cover SHOW_AHEAD=1: push 0xA5 into the empty FIFO -> the next cycle dout=0xA5 and rd_valid=1 with no rd_en.
REQ-039 SHALL cover reset mid-operation: count=9, assert rst_n=0 between edges -> empty=1, count=0 and dout=0 immediately; clr_err clears the sticky flags.
